modport_slave: RTL and testbench
================================

MODPORT_SLAVE -- requirements
Module: modport_slave

Interface
REQ-001 Parameter ADDR_W, default 8, byte-address width.
REQ-002 Parameter DATA_W, default 32, data width; fixed at 32 for this block.
REQ-003 ACLK  input  1  single clock; all logic on rising edge.
REQ-004 ARESET  input  1  asynchronous, active-high reset.
REQ-005 S_AXI_awaddr/awprot/awvalid  input  ADDR_W/3/1  write address channel; awready  output  1.
REQ-006 S_AXI_wdata/wstrb/wvalid  input  DATA_W/DATA_W/8/1  write data channel; wready  output  1.
REQ-007 S_AXI_bresp/bvalid  output  2/1  write response; bready  input  1.
REQ-008 S_AXI_araddr/arprot/arvalid  input  ADDR_W/3/1  read address; arready  output  1.
REQ-009 S_AXI_rdata/rresp/rvalid  output  DATA_W/2/1  read data; rready  input  1.

Function
REQ-010 Register bank: 16 x 32-bit registers at byte offsets 0x00-0x3C; index = addr[5:2]; addr[1:0] ignored; awprot/arprot ignored.
REQ-011 Offsets 0x00-0x38 read/write; offset 0x3C read-only ID = 0xA5A5_0001, writes to it ignored with OKAY.
REQ-012 Addresses >= 0x40: write discarded, bresp = SLVERR (2'b10); read returns rdata 0, rresp SLVERR.
REQ-013 Write strobes: byte lane i updated only when wstrb[i]=1; wstrb=0 leaves register unchanged, OKAY.
REQ-014 awready=1 while no AW is latched and no B is pending; wready=1 while no W is latched and no B is pending.
REQ-015 AW and W are accepted independently in any order or the same cycle, each held in its own buffer.
REQ-016 When both buffers are full, the write commits in that cycle; bvalid rises the following cycle.
REQ-017 bvalid/bresp stay stable until bready is high at a rising edge; then bvalid drops and both readies reassert next cycle.
REQ-018 Write throughput is one transaction per 2 cycles minimum; at most one write outstanding.
REQ-019 arready=1 while rvalid=0; AR handshake latches the address and produces rvalid, rdata, rresp the next cycle.
REQ-020 rvalid/rdata/rresp stay stable until rready is high at a rising edge; arready is 0 while rvalid=1.
REQ-021 A read accepted in the same cycle that a write commits to the same register returns the pre-write value.
REQ-022 Read and write paths are fully independent; neither stalls the other.
REQ-023 bresp/rresp are OKAY (2'b00) unless REQ-012 applies; EXOKAY/DECERR are never produced.

Reset
REQ-024 While ARESET=1: awready, wready, arready, bvalid, rvalid = 0; bresp, rresp, rdata = 0; all RW registers = 0; AW/W buffers empty.
REQ-025 awready, wready, arready = 1 on the first rising edge after ARESET deasserts.
REQ-026 Reset asserted mid-transaction abandons it; no response is issued for it afterward.

Structure
REQ-027 Shared package modport_pkg holds the response codes (OKAY, SLVERR), NUM_REGS=16, the ID value, and the register-index typedef.
REQ-028 Single module; the register file is inline, with no sub-module.

Verification
REQ-029 Write 0x1234_5678 to 0x04 with wstrb=0xF, AW and W in the same cycle -> bvalid the next cycle with OKAY; read of 0x04 returns 0x1234_5678 with OKAY.
REQ-030 W first, AW three cycles later, wstrb=0x3, data 0xFFFF_FFFF to 0x08 after reset -> read of 0x08 = 0x0000_FFFF.
REQ-031 Write to 0x40 -> bresp SLVERR; read of 0x44 -> rdata 0, rresp SLVERR; write 0xDEAD_BEEF to 0x3C -> OKAY and read of 0x3C = 0xA5A5_0001.
REQ-032 Hold bready=0 for 5 cycles -> bvalid/bresp stable and awready/wready = 0 throughout; hold rready=0 -> rdata stable and arready = 0.
REQ-033 Assert ARESET mid-write after AW is accepted but before W -> all outputs 0 and registers 0; after release, readies = 1 and no bvalid appears.
REQ-034 Write 0x55 and read of 0x0C in the same commit cycle, with the register previously 0x11 -> read returns 0x11; a following read returns 0x55.

Source files
------------

// File: rtl/modport_slave_pkg.sv
// rtl/modport_slave_pkg.sv - shared constants, types and FSM encodings for modport_slave
package modport_pkg;

    localparam int NUM_REGS = 16;

    localparam logic [31:0] ID_VALUE = 32'hA5A5_0001;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef logic [$clog2(NUM_REGS)-1:0] reg_idx_t;

    // Top slot of the bank is the read-only identification word
    localparam reg_idx_t ID_IDX = reg_idx_t'(NUM_REGS - 1);

    typedef enum logic [2:0] {
        WR_RESET,
        WR_IDLE,
        WR_HAVE_AW,
        WR_HAVE_W,
        WR_RESP
    } wr_state_t;

    typedef enum logic [1:0] {
        RD_RESET,
        RD_IDLE,
        RD_RESP
    } rd_state_t;

endpackage

// File: rtl/modport_slave_if.sv
// rtl/modport_slave_if.sv - register-bus channel bundle with master/slave modports
interface modport_slave_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   awaddr;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;

    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;

    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    logic [ADDR_W-1:0]   araddr;
    logic [2:0]          arprot;
    logic                arvalid;
    logic                arready;

    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input rdata, rresp, rvalid, output rready
    );

    modport slave (
        input awaddr, awprot, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/modport_slave.sv
// rtl/modport_slave.sv - 16x32 register bank slave with independent write and read channels
module modport_slave
    import modport_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic             ACLK,
    input  logic             ARESET,
    modport_slave_if.slave   S_AXI
);

    localparam int STRB_W = DATA_W / 8;

    wr_state_t           wr_state, wr_next;
    rd_state_t           rd_state, rd_next;

    logic                awready_c, wready_c, bvalid_c, commit;
    logic                arready_c, rvalid_c, ar_hs;

    logic [ADDR_W-1:0]   aw_addr_q;
    logic [DATA_W-1:0]   w_data_q;
    logic [STRB_W-1:0]   w_strb_q;

    logic [ADDR_W-1:0]   wr_addr;
    logic [DATA_W-1:0]   wr_data;
    logic [STRB_W-1:0]   wr_strb;
    reg_idx_t            wr_idx, rd_idx;
    logic                wr_oob, rd_oob;

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [1:0]          bresp_q, rresp_q;
    logic [DATA_W-1:0]   rdata_q;

    logic                unused_bits;

    // A buffered half wins over the live bus; otherwise the half arrives this very cycle
    assign wr_addr = (wr_state == WR_HAVE_AW) ? aw_addr_q : S_AXI.awaddr;
    assign wr_data = (wr_state == WR_HAVE_W)  ? w_data_q  : S_AXI.wdata;
    assign wr_strb = (wr_state == WR_HAVE_W)  ? w_strb_q  : S_AXI.wstrb;
    assign wr_idx  = wr_addr[5:2];
    assign wr_oob  = |wr_addr[ADDR_W-1:6];

    assign rd_idx  = S_AXI.araddr[5:2];
    assign rd_oob  = |S_AXI.araddr[ADDR_W-1:6];
    assign ar_hs   = arready_c & S_AXI.arvalid;

    assign unused_bits = ^{S_AXI.awprot, S_AXI.arprot, wr_addr[1:0], S_AXI.araddr[1:0]};

    // Write channel state register
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) wr_state <= WR_RESET;
        else        wr_state <= wr_next;
    end

    // Write channel sequencing: collect AW and W in any order, commit when the pair completes
    always_comb begin
        wr_next   = wr_state;
        awready_c = 1'b0;
        wready_c  = 1'b0;
        bvalid_c  = 1'b0;
        commit    = 1'b0;
        case (wr_state)
            WR_RESET: wr_next = WR_IDLE;
            WR_IDLE: begin
                awready_c = 1'b1;
                wready_c  = 1'b1;
                if (S_AXI.awvalid && S_AXI.wvalid) begin
                    commit  = 1'b1;
                    wr_next = WR_RESP;
                end else if (S_AXI.awvalid) begin
                    wr_next = WR_HAVE_AW;
                end else if (S_AXI.wvalid) begin
                    wr_next = WR_HAVE_W;
                end
            end
            WR_HAVE_AW: begin
                wready_c = 1'b1;
                if (S_AXI.wvalid) begin
                    commit  = 1'b1;
                    wr_next = WR_RESP;
                end
            end
            WR_HAVE_W: begin
                awready_c = 1'b1;
                if (S_AXI.awvalid) begin
                    commit  = 1'b1;
                    wr_next = WR_RESP;
                end
            end
            WR_RESP: begin
                bvalid_c = 1'b1;
                if (S_AXI.bready) wr_next = WR_IDLE;
            end
            default: wr_next = WR_IDLE;
        endcase
    end

    // Hold whichever write half arrived first until its partner shows up
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
        end else begin
            if (awready_c && S_AXI.awvalid) aw_addr_q <= S_AXI.awaddr;
            if (wready_c && S_AXI.wvalid) begin
                w_data_q <= S_AXI.wdata;
                w_strb_q <= S_AXI.wstrb;
            end
        end
    end

    // Register bank update with per-byte strobes; ID slot and out-of-range writes are dropped
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (commit && !wr_oob && (wr_idx != ID_IDX)) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wr_strb[b]) regs[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

    // Write response code, captured at commit and held while bvalid waits
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET)      bresp_q <= RESP_OKAY;
        else if (commit) bresp_q <= wr_oob ? RESP_SLVERR : RESP_OKAY;
    end

    // Read channel state register
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) rd_state <= RD_RESET;
        else        rd_state <= rd_next;
    end

    // Read channel sequencing: one outstanding read, address accepted only while no data waits
    always_comb begin
        rd_next   = rd_state;
        arready_c = 1'b0;
        rvalid_c  = 1'b0;
        case (rd_state)
            RD_RESET: rd_next = RD_IDLE;
            RD_IDLE: begin
                arready_c = 1'b1;
                if (S_AXI.arvalid) rd_next = RD_RESP;
            end
            RD_RESP: begin
                rvalid_c = 1'b1;
                if (S_AXI.rready) rd_next = RD_IDLE;
            end
            default: rd_next = RD_IDLE;
        endcase
    end

    // Read data capture; sampling the bank before a same-edge commit yields the old value
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            rdata_q <= '0;
            rresp_q <= RESP_OKAY;
        end else if (ar_hs) begin
            if (rd_oob) begin
                rdata_q <= '0;
                rresp_q <= RESP_SLVERR;
            end else begin
                rdata_q <= (rd_idx == ID_IDX) ? ID_VALUE : regs[rd_idx];
                rresp_q <= RESP_OKAY;
            end
        end
    end

    assign S_AXI.awready = awready_c;
    assign S_AXI.wready  = wready_c;
    assign S_AXI.bvalid  = bvalid_c;
    assign S_AXI.bresp   = bresp_q;
    assign S_AXI.arready = arready_c;
    assign S_AXI.rvalid  = rvalid_c;
    assign S_AXI.rdata   = rdata_q;
    assign S_AXI.rresp   = rresp_q;

endmodule

// File: tb/tb_modport_slave.sv
// tb/tb_modport_slave.sv - self-checking bench for modport_slave against a register-array model
module tb_modport_slave;

    logic ACLK;
    logic ARESET;

    modport_slave_if #(.ADDR_W(8), .DATA_W(32)) S_AXI ();

    modport_slave #(.ADDR_W(8), .DATA_W(32)) dut (
        .ACLK   (ACLK),
        .ARESET (ARESET),
        .S_AXI  (S_AXI)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] model [16];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_rdata(input logic [7:0] addr);
        if (addr >= 8'h40)          return 32'h0;
        else if (addr[5:2] == 4'hF) return 32'hA5A5_0001;
        else                        return model[addr[5:2]];
    endfunction

    function automatic logic [1:0] exp_resp(input logic [7:0] addr);
        return (addr >= 8'h40) ? 2'b10 : 2'b00;
    endfunction

    task automatic model_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb);
        if (addr < 8'h40 && addr[5:2] != 4'hF) begin
            for (int b = 0; b < 4; b++)
                if (strb[b]) model[addr[5:2]][8*b +: 8] = data[8*b +: 8];
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    // gap 0: AW and W together; gap>0: W first, AW gap cycles later; gap<0: AW first
    task automatic do_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int gap, input int bhold);
        check("awready_before_write", S_AXI.awready, 1);
        check("wready_before_write", S_AXI.wready, 1);
        S_AXI.awaddr = addr;
        S_AXI.awprot = 3'($urandom);
        S_AXI.wdata  = data;
        S_AXI.wstrb  = strb;
        if (gap == 0) begin
            S_AXI.awvalid = 1'b1;
            S_AXI.wvalid  = 1'b1;
            tick();
            S_AXI.awvalid = 1'b0;
            S_AXI.wvalid  = 1'b0;
        end else if (gap > 0) begin
            S_AXI.wvalid = 1'b1;
            tick();
            S_AXI.wvalid = 1'b0;
            check("w_only_awready", S_AXI.awready, 1);
            check("w_only_wready", S_AXI.wready, 0);
            repeat (gap - 1) tick();
            check("w_only_no_bvalid", S_AXI.bvalid, 0);
            S_AXI.awvalid = 1'b1;
            tick();
            S_AXI.awvalid = 1'b0;
        end else begin
            S_AXI.awvalid = 1'b1;
            tick();
            S_AXI.awvalid = 1'b0;
            check("aw_only_awready", S_AXI.awready, 0);
            check("aw_only_wready", S_AXI.wready, 1);
            repeat (-gap - 1) tick();
            check("aw_only_no_bvalid", S_AXI.bvalid, 0);
            S_AXI.wvalid = 1'b1;
            tick();
            S_AXI.wvalid = 1'b0;
        end
        model_write(addr, data, strb);
        check("bvalid_after_commit", S_AXI.bvalid, 1);
        check("bresp", S_AXI.bresp, exp_resp(addr));
        check("awready_during_b", S_AXI.awready, 0);
        check("wready_during_b", S_AXI.wready, 0);
        for (int i = 0; i < bhold; i++) begin
            tick();
            check("bvalid_held", S_AXI.bvalid, 1);
            check("bresp_held", S_AXI.bresp, exp_resp(addr));
            check("awready_held_low", S_AXI.awready, 0);
            check("wready_held_low", S_AXI.wready, 0);
        end
        S_AXI.bready = 1'b1;
        tick();
        S_AXI.bready = 1'b0;
        check("bvalid_dropped", S_AXI.bvalid, 0);
        check("awready_reasserted", S_AXI.awready, 1);
    endtask

    task automatic do_read(input logic [7:0] addr, input int rhold);
        logic [31:0] exp;
        exp = exp_rdata(addr);
        check("arready_before_read", S_AXI.arready, 1);
        S_AXI.araddr  = addr;
        S_AXI.arprot  = 3'($urandom);
        S_AXI.arvalid = 1'b1;
        tick();
        S_AXI.arvalid = 1'b0;
        check("rvalid", S_AXI.rvalid, 1);
        check("rdata", S_AXI.rdata, exp);
        check("rresp", S_AXI.rresp, exp_resp(addr));
        check("arready_during_r", S_AXI.arready, 0);
        for (int i = 0; i < rhold; i++) begin
            tick();
            check("rvalid_held", S_AXI.rvalid, 1);
            check("rdata_held", S_AXI.rdata, exp);
            check("arready_held_low", S_AXI.arready, 0);
        end
        S_AXI.rready = 1'b1;
        tick();
        S_AXI.rready = 1'b0;
        check("rvalid_dropped", S_AXI.rvalid, 0);
        check("arready_reasserted", S_AXI.arready, 1);
    endtask

    initial begin
        logic [7:0]  a;
        logic [31:0] d;
        logic [3:0]  s;
        int          g;

        for (int i = 0; i < 16; i++) model[i] = 32'h0;
        ARESET        = 1'b1;
        S_AXI.awaddr  = '0;
        S_AXI.awprot  = '0;
        S_AXI.awvalid = 1'b0;
        S_AXI.wdata   = '0;
        S_AXI.wstrb   = '0;
        S_AXI.wvalid  = 1'b0;
        S_AXI.bready  = 1'b0;
        S_AXI.araddr  = '0;
        S_AXI.arprot  = '0;
        S_AXI.arvalid = 1'b0;
        S_AXI.rready  = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_awready", S_AXI.awready, 0);
        check("rst_wready", S_AXI.wready, 0);
        check("rst_arready", S_AXI.arready, 0);
        check("rst_bvalid", S_AXI.bvalid, 0);
        check("rst_rvalid", S_AXI.rvalid, 0);
        check("rst_bresp", S_AXI.bresp, 0);
        check("rst_rresp", S_AXI.rresp, 0);
        check("rst_rdata", S_AXI.rdata, 0);
        ARESET = 1'b0;
        tick();
        check("post_rst_awready", S_AXI.awready, 1);
        check("post_rst_wready", S_AXI.wready, 1);
        check("post_rst_arready", S_AXI.arready, 1);

        // W first, AW three cycles later, low half-word strobe on a fresh register
        do_write(8'h08, 32'hFFFF_FFFF, 4'h3, 3, 0);
        do_read(8'h08, 0);
        check("strobe_low_half", model[2], 32'h0000_FFFF);

        // Same-cycle AW/W, full strobe
        do_write(8'h04, 32'h1234_5678, 4'hF, 0, 0);
        do_read(8'h04, 0);

        // Out-of-range and read-only ID
        do_write(8'h40, 32'hCAFE_F00D, 4'hF, 0, 0);
        do_read(8'h44, 0);
        do_write(8'h3C, 32'hDEAD_BEEF, 4'hF, 0, 0);
        do_read(8'h3C, 0);

        // Zero strobe leaves register alone; addr[1:0] ignored
        do_write(8'h07, 32'h0BAD_0BAD, 4'h0, -2, 0);
        do_read(8'h05, 0);

        // Back-pressure on both response channels
        do_write(8'h10, 32'h0A0B_0C0D, 4'hF, 0, 5);
        do_read(8'h10, 5);

        // Read accepted in the commit cycle sees the pre-write value
        do_write(8'h0C, 32'h0000_0011, 4'hF, 0, 0);
        S_AXI.awaddr  = 8'h0C;
        S_AXI.wdata   = 32'h0000_0055;
        S_AXI.wstrb   = 4'hF;
        S_AXI.araddr  = 8'h0C;
        S_AXI.awvalid = 1'b1;
        S_AXI.wvalid  = 1'b1;
        S_AXI.arvalid = 1'b1;
        tick();
        S_AXI.awvalid = 1'b0;
        S_AXI.wvalid  = 1'b0;
        S_AXI.arvalid = 1'b0;
        check("collide_bvalid", S_AXI.bvalid, 1);
        check("collide_rvalid", S_AXI.rvalid, 1);
        check("collide_rdata_old", S_AXI.rdata, 32'h0000_0011);
        model_write(8'h0C, 32'h0000_0055, 4'hF);
        S_AXI.bready = 1'b1;
        S_AXI.rready = 1'b1;
        tick();
        S_AXI.bready = 1'b0;
        S_AXI.rready = 1'b0;
        do_read(8'h0C, 0);

        // Randomized traffic against the array model
        for (int n = 0; n < 40; n++) begin
            a = 8'($urandom_range(0, 8'h4F));
            d = $urandom;
            s = 4'($urandom);
            g = int'($urandom_range(0, 6)) - 3;
            do_write(a, d, s, g, int'($urandom_range(0, 2)));
            do_read(8'($urandom_range(0, 8'h4F)), int'($urandom_range(0, 2)));
        end

        // Reset in the middle of a write whose AW is already latched
        S_AXI.awaddr  = 8'h14;
        S_AXI.awvalid = 1'b1;
        tick();
        S_AXI.awvalid = 1'b0;
        check("mid_aw_latched", S_AXI.awready, 0);
        #3;
        ARESET = 1'b1;
        #1;
        check("mid_rst_awready", S_AXI.awready, 0);
        check("mid_rst_wready", S_AXI.wready, 0);
        check("mid_rst_arready", S_AXI.arready, 0);
        check("mid_rst_bvalid", S_AXI.bvalid, 0);
        check("mid_rst_rvalid", S_AXI.rvalid, 0);
        check("mid_rst_bresp", S_AXI.bresp, 0);
        check("mid_rst_rdata", S_AXI.rdata, 0);
        for (int i = 0; i < 16; i++) model[i] = 32'h0;
        tick();
        tick();
        ARESET = 1'b0;
        tick();
        check("rel_awready", S_AXI.awready, 1);
        check("rel_wready", S_AXI.wready, 1);
        check("rel_arready", S_AXI.arready, 1);
        check("rel_bvalid", S_AXI.bvalid, 0);
        do_read(8'h04, 0);
        do_read(8'h0C, 0);
        do_read(8'h3C, 0);
        S_AXI.wdata  = 32'h7777_7777;
        S_AXI.wvalid = 1'b1;
        tick();
        S_AXI.wvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("abandoned_no_bvalid", S_AXI.bvalid, 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
